// File: rtl/alu_issue_pkg.sv
// Decode constants and the issue payload bundle shared by the
// alu_issue stage, its interfaces and its immediate generator.
`include "types.sv"

package issue_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = `ALU_SEL_SIZE;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t A_ADD  = `ALU_ADD;
  localparam sel_t A_SUB  = `ALU_SUB;
  localparam sel_t A_SLL  = `ALU_SLL;
  localparam sel_t A_SLT  = `ALU_SLT;
  localparam sel_t A_SLTU = `ALU_SLTU;
  localparam sel_t A_XOR  = `ALU_XOR;
  localparam sel_t A_SRL  = `ALU_SRL;
  localparam sel_t A_SRA  = `ALU_SRA;
  localparam sel_t A_OR   = `ALU_OR;
  localparam sel_t A_AND  = `ALU_AND;
  localparam sel_t A_CMP  = `ALU_CMP;
  localparam sel_t A_NOP  = `ALU_NOP;
  localparam sel_t A_INV  = `ALU_INVALID;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_Z   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    sel_t            sel;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic            br_invert;
    logic            illegal;
  } issue_t;

  function automatic sel_t f3_op(logic [2:0] f3);
    sel_t s;
    s = A_ADD;
    unique case (f3)
      F3_ADD:  s = A_ADD;
      F3_SLL:  s = A_SLL;
      F3_SLT:  s = A_SLT;
      F3_SLTU: s = A_SLTU;
      F3_XOR:  s = A_XOR;
      F3_SR:   s = A_SRL;
      F3_OR:   s = A_OR;
      F3_AND:  s = A_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream (register read) and downstream (execute) handshake
// bundles for the alu_issue stage.
interface issue_in_if #(parameter int DW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_rs1;
  logic [DW-1:0] in_rs2;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2,
    input  in_ready
  );
  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2,
    output in_ready
  );
endinterface

interface issue_out_if #(parameter int DW = 32);
  import issue_pkg::*;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  sel_t          alu_sel;
  logic [4:0]    rd;
  logic          rd_we;
  logic          is_branch;
  logic          br_invert;
  logic          illegal;

  modport master (
    output out_valid, alu_a, alu_b, alu_sel, rd,
    output rd_we, is_branch, br_invert, illegal,
    input  out_ready
  );
  modport slave (
    input  out_valid, alu_a, alu_b, alu_sel, rd,
    input  rd_we, is_branch, br_invert, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_imm_gen.sv
// I/U immediates and shift amount extracted from an RV32I word.
module imm_gen
  import issue_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] shamt
);

  logic unused_lo;

  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt     = {27'b0, instr[24:20]};
  assign unused_lo = ^instr[11:0];

endmodule

// File: rtl/types.sv
// Shared ALU operation codes and datapath width for the core.
// Guarded so every file that needs the codes can pull them in.
`ifndef TYPES_SV
`define TYPES_SV

`define DATA_WIDTH   32
`define ALU_SEL_SIZE 4

`define ALU_ADD     4'd0
`define ALU_SUB     4'd1
`define ALU_SLL     4'd2
`define ALU_SLT     4'd3
`define ALU_SLTU    4'd4
`define ALU_XOR     4'd5
`define ALU_SRL     4'd6
`define ALU_SRA     4'd7
`define ALU_OR      4'd8
`define ALU_AND     4'd9
`define ALU_CMP     4'd10
`define ALU_NOP     4'd14
`define ALU_INVALID 4'd15

`endif

// File: rtl/alu_issue.sv
// Decode-and-issue stage: RV32I word to ALU select/operands,
// held in a one-entry valid/ready output register.
`include "types.sv"

module alu_issue
  import issue_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  issue_in_if.slave   up,
  issue_out_if.master dn
);

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic        legal, wr, acc;
  issue_t      d, q;
  logic        vld;

  assign instr = up.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  imm_gen u_imm (
    .instr (instr),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .shamt (shamt)
  );

  always_comb begin
    d     = '0;
    legal = 1'b1;
    wr    = 1'b0;
    d.rd  = instr[11:7];
    unique case (1'b1)
      (opc == OPC_IMM): begin
        wr    = 1'b1;
        d.a   = up.in_rs1;
        d.b   = imm_i;
        d.sel = f3_op(f3);
        if (f3 == F3_SLL) begin
          d.b   = shamt;
          legal = (f7 == F7_Z);
        end else if (f3 == F3_SR) begin
          d.b   = shamt;
          d.sel = (f7 == F7_ALT) ? A_SRA : A_SRL;
          legal = (f7 == F7_Z) || (f7 == F7_ALT);
        end
      end
      (opc == OPC_OP): begin
        wr  = 1'b1;
        d.a = up.in_rs1;
        d.b = up.in_rs2;
        if (f7 == F7_Z) begin
          d.sel = f3_op(f3);
        end else if (f7 == F7_ALT) begin
          d.sel = (f3 == F3_ADD) ? A_SUB : A_SRA;
          legal = (f3 == F3_ADD) || (f3 == F3_SR);
        end else begin
          legal = 1'b0;
        end
      end
      (opc == OPC_LUI): begin
        wr    = 1'b1;
        d.b   = imm_u;
        d.sel = A_ADD;
      end
      (opc == OPC_AUIPC): begin
        wr    = 1'b1;
        d.a   = up.in_pc;
        d.b   = imm_u;
        d.sel = A_ADD;
      end
      (opc == OPC_BR): begin
        d.a         = up.in_rs1;
        d.b         = up.in_rs2;
        d.is_branch = 1'b1;
        d.br_invert = f3[0];
        unique case (f3)
          F3_BEQ, F3_BNE:   d.sel = A_CMP;
          F3_BLT, F3_BGE:   d.sel = A_SLT;
          F3_BLTU, F3_BGEU: d.sel = A_SLTU;
          default:          legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // illegal entries still issue, but carry no operands or branch info
    if (!legal) begin
      d.a         = '0;
      d.b         = '0;
      d.sel       = A_INV;
      d.is_branch = 1'b0;
      d.br_invert = 1'b0;
    end
    d.illegal = !legal;
    d.rd_we   = legal && wr && (d.rd != 5'd0);
  end

  assign up.in_ready = !flush && (!vld || dn.out_ready);
  assign acc         = up.in_valid && up.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= 1'b0;
      q     <= '0;
      q.sel <= A_NOP;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (acc) begin
      vld <= 1'b1;
      q   <= d;
    end else if (dn.out_ready) begin
      vld <= 1'b0;
    end
  end

  assign dn.out_valid = vld;
  assign dn.alu_a     = q.a;
  assign dn.alu_b     = q.b;
  assign dn.alu_sel   = q.sel;
  assign dn.rd        = q.rd;
  assign dn.rd_we     = q.rd_we;
  assign dn.is_branch = q.is_branch;
  assign dn.br_invert = q.br_invert;
  assign dn.illegal   = q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode vectors, handshake
// corner sequences and a randomized run against a reference model.
module tb_alu_issue;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  issue_in_if  #(.DW(32)) up ();
  issue_out_if #(.DW(32)) dn ();

  alu_issue #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .up    (up),
    .dn    (dn)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    issue_t      exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic issue_t got();
    issue_t g;
    g.a         = dn.alu_a;
    g.b         = dn.alu_b;
    g.sel       = dn.alu_sel;
    g.rd        = dn.rd;
    g.rd_we     = dn.rd_we;
    g.is_branch = dn.is_branch;
    g.br_invert = dn.br_invert;
    g.illegal   = dn.illegal;
    return g;
  endfunction

  function automatic issue_t mk(logic [31:0] a, logic [31:0] b,
                                sel_t s, logic [4:0] rd,
                                logic we, logic br, logic inv,
                                logic ill);
    issue_t e;
    e.a = a; e.b = b; e.sel = s; e.rd = rd;
    e.rd_we = we; e.is_branch = br;
    e.br_invert = inv; e.illegal = ill;
    return e;
  endfunction

  // reference decode, table-driven from the instruction-set rules
  function automatic issue_t ref_dec(logic [31:0] i, logic [31:0] pc,
                                     logic [31:0] r1, logic [31:0] r2);
    sel_t   base[8];
    sel_t   brs[8];
    bit     brok[8];
    issue_t e;
    bit     ok;
    bit     wr;
    int     f3;
    int     f7;
    int     imm;
    base = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    brs  = '{A_CMP, A_CMP, A_INV, A_INV, A_SLT, A_SLT, A_SLTU, A_SLTU};
    brok = '{1, 1, 0, 0, 1, 1, 1, 1};
    f3   = int'(i[14:12]);
    f7   = int'(i[31:25]);
    imm  = int'($signed(i[31:20]));
    e    = mk(0, 0, A_INV, i[11:7], 0, 0, 0, 0);
    ok   = 0;
    wr   = 0;
    if (i[6:0] == 7'h13) begin
      wr = 1; e.a = r1; e.b = imm; e.sel = base[f3]; ok = 1;
      if (f3 == 1) begin
        e.b = {27'b0, i[24:20]}; ok = (f7 == 0);
      end
      if (f3 == 5) begin
        e.b = {27'b0, i[24:20]};
        ok = (f7 == 0) || (f7 == 32);
        if (f7 == 32) e.sel = A_SRA;
      end
    end else if (i[6:0] == 7'h33) begin
      wr = 1; e.a = r1; e.b = r2;
      if (f7 == 0) begin
        ok = 1; e.sel = base[f3];
      end else if (f7 == 32 && f3 == 0) begin
        ok = 1; e.sel = A_SUB;
      end else if (f7 == 32 && f3 == 5) begin
        ok = 1; e.sel = A_SRA;
      end
    end else if (i[6:0] == 7'h37) begin
      wr = 1; ok = 1; e.sel = A_ADD;
      e.a = 0; e.b = i[31:12] * 4096;
    end else if (i[6:0] == 7'h17) begin
      wr = 1; ok = 1; e.sel = A_ADD;
      e.a = pc; e.b = i[31:12] * 4096;
    end else if (i[6:0] == 7'h63) begin
      ok = brok[f3];
      e.a = r1; e.b = r2; e.sel = brs[f3];
      e.is_branch = 1; e.br_invert = (f3 % 2 == 1);
    end
    if (!ok) e = mk(0, 0, A_INV, i[11:7], 0, 0, 0, 0);
    e.illegal = !ok;
    e.rd_we   = ok && wr && (i[11:7] != 0);
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] i;
    int          k;
    i = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: i[6:0] = 7'h33;
      1: i[6:0] = 7'h13;
      2: i[6:0] = 7'h37;
      3: i[6:0] = 7'h17;
      4: i[6:0] = 7'h63;
      default: ;
    endcase
    k = $urandom_range(0, 2);
    if (k == 0) i[31:25] = 7'h00;
    if (k == 1) i[31:25] = 7'h20;
    return i;
  endfunction

  task automatic drive(logic v, logic [31:0] i, logic [31:0] pc,
                       logic [31:0] r1, logic [31:0] r2);
    up.in_valid = v;
    up.in_instr = i;
    up.in_pc    = pc;
    up.in_rs1   = r1;
    up.in_rs2   = r2;
  endtask

  issue_t rst_e;
  issue_t held;
  issue_t me;
  bit     mv;
  bit     er;

  initial begin
    rst_e = mk(0, 0, A_NOP, 0, 0, 0, 0, 0);

    vecs[0]  = '{"addi", 32'hFFF08293, 0, 32'h10, 0,
                 mk(32'h10, 32'hFFFFFFFF, A_ADD, 5, 1, 0, 0, 0)};
    vecs[1]  = '{"srai", 32'h40415193, 0, 32'h80000000, 0,
                 mk(32'h80000000, 4, A_SRA, 3, 1, 0, 0, 0)};
    vecs[2]  = '{"srai_bad", 32'h42415193, 0, 32'h5, 0,
                 mk(0, 0, A_INV, 3, 0, 0, 0, 1)};
    vecs[3]  = '{"bgeu", 32'h0020F063, 0, 1, 2,
                 mk(1, 2, A_SLTU, 0, 0, 1, 1, 0)};
    vecs[4]  = '{"auipc", 32'h12345097, 32'h100, 7, 9,
                 mk(32'h100, 32'h12345000, A_ADD, 1, 1, 0, 0, 0)};
    vecs[5]  = '{"lui_x0", 32'h00001037, 0, 7, 9,
                 mk(0, 32'h1000, A_ADD, 0, 0, 0, 0, 0)};
    vecs[6]  = '{"sub", 32'h404183B3, 0, 32'h30, 32'h4,
                 mk(32'h30, 4, A_SUB, 7, 1, 0, 0, 0)};
    vecs[7]  = '{"bne", 32'h00209063, 0, 3, 3,
                 mk(3, 3, A_CMP, 0, 0, 1, 1, 0)};
    vecs[8]  = '{"bad_opc", 32'h00000F8B, 0, 3, 3,
                 mk(0, 0, A_INV, 31, 0, 0, 0, 1)};
    vecs[9]  = '{"br_f3_010", 32'h0020A063, 0, 3, 3,
                 mk(0, 0, A_INV, 0, 0, 0, 0, 1)};
    vecs[10] = '{"op_f7_1", 32'h022080B3, 0, 3, 3,
                 mk(0, 0, A_INV, 1, 0, 0, 0, 1)};
    vecs[11] = '{"xori", 32'h7FF04113, 0, 32'hAA, 0,
                 mk(32'hAA, 32'h7FF, A_XOR, 2, 1, 0, 0, 0)};

    rst = 1'b1;
    flush = 1'b0;
    dn.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", 128'(dn.out_valid), 0);
    chk("rst_payload", got(), rst_e);
    chk("rst_in_ready", 128'(up.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(1, vecs[k].instr, vecs[k].pc, vecs[k].r1, vecs[k].r2);
      @(posedge clk);
      #1;
      chk({vecs[k].nm, "_valid"}, 128'(dn.out_valid), 1);
      chk(vecs[k].nm, got(), vecs[k].exp);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("drain_valid", 128'(dn.out_valid), 0);

    // backpressure: stall three cycles, then stream
    @(negedge clk);
    drive(1, 32'hFFF08293, 0, 32'h10, 0);
    @(posedge clk);
    #1;
    held = mk(32'h10, 32'hFFFFFFFF, A_ADD, 5, 1, 0, 0, 0);
    @(negedge clk);
    dn.out_ready = 1'b0;
    drive(1, 32'h7FF04113, 0, 32'h1, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 128'(up.in_ready), 0);
      @(posedge clk);
      #1;
      chk("stall_valid", 128'(dn.out_valid), 1);
      chk("stall_payload", got(), held);
      @(negedge clk);
    end
    dn.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1, {20'(c + 1), 5'(c + 10), 7'h37}, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("stream_valid", 128'(dn.out_valid), 1);
      chk("stream_rd", 128'(dn.rd), 128'(c + 10));
      chk("stream_b", 128'(dn.alu_b), 128'((c + 1) * 4096));
      @(negedge clk);
    end

    // flush while stalled drops held entry and same-cycle input
    dn.out_ready = 1'b0;
    drive(1, 32'h00001A37, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    drive(1, 32'h00001AB7, 0, 0, 0);
    #1;
    chk("flush_in_ready", 128'(up.in_ready), 0);
    @(posedge clk);
    #1;
    chk("flush_valid", 128'(dn.out_valid), 0);
    @(negedge clk);
    flush = 1'b0;
    dn.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("flush_dropped", 128'(dn.out_valid), 0);

    // asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(1, 32'hFFF08293, 0, 32'h10, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 128'(dn.out_valid), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    dn.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(dn.out_valid), 0);
    chk("arst_payload", got(), rst_e);
    chk("arst_in_ready", 128'(up.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(up.in_ready), 1);

    // randomized handshake + decode against the model
    me = rst_e;
    mv = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      flush        = ($urandom_range(0, 9) == 0);
      dn.out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, gen(), $urandom,
            $urandom, $urandom);
      #1;
      er = !flush && (!mv || dn.out_ready);
      chk("rnd_valid", 128'(dn.out_valid), 128'(mv));
      chk("rnd_payload", got(), me);
      chk("rnd_in_ready", 128'(up.in_ready), 128'(er));
      if (flush) begin
        mv = 0;
      end else if (up.in_valid && er) begin
        mv = 1;
        me = ref_dec(up.in_instr, up.in_pc, up.in_rs1, up.in_rs2);
      end else if (dn.out_ready) begin
        mv = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage feeding the ALU: it accepts one RV32I instruction with its register-file operands and PC, and decodes the ALU operation and operand selection. It registers the result into a one-entry output stage with valid/ready handshakes on both sides. It sits between register read and the ALU/execute stage. It produces the `alu_sel`, `a` and `b` values the ALU consumes, plus writeback and branch-sense side information.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH`` (32): operand/PC width; the immediate and shift rules below require 32.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  DATA_WIDTH  instruction address.
- `in_rs1`, `in_rs2`  in  DATA_WIDTH  register-file read values.
- `flush`  in  1  discard the held entry and any same-cycle input.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  execute stage consumes the entry this cycle.
- `alu_a`, `alu_b`  out  DATA_WIDTH  ALU operands.
- `alu_sel`  out  `` `ALU_SEL_SIZE``  ALU operation code.
- `rd`  out  5  destination register.
- `rd_we`  out  1  writeback enable.
- `is_branch`  out  1  the entry is a conditional branch; ALU bit 0 is the condition.
- `br_invert`  out  1  the taken condition is the inverse of ALU bit 0.
- `illegal`  out  1  the instruction was not decodable by this stage.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !flush && (!out_valid || out_ready)`.
- **OP-IMM (0010011):** `a=rs1`, `b=imm_i` (sign-extended).
  - funct3 mapping: ADDI→ADD, SLTI→SLT, SLTIU→SLTU, XORI→XOR, ORI→OR, ANDI→AND.
  - SLLI needs funct7=0000000. SRLI/SRAI need funct7=0000000/0100000 and map to SRL/SRA; `b=instr[24:20]` zero-extended.
  - Any other funct7 for a shift makes the instruction illegal.
- **OP (0110011):** `a=rs1`, `b=rs2`.
  - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - funct7=0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - Any other funct7 is illegal.
- **LUI:** `a=0`, `b=instr[31:12]<<12`, ADD.
- **AUIPC:** `a=pc`, `b=imm_u`, ADD.
- **BRANCH (1100011):** `a=rs1`, `b=rs2`, `is_branch=1`, `rd_we=0`.
  - BEQ→CMP; BNE→CMP with `br_invert=1`.
  - BLT→SLT; BGE→SLT with `br_invert=1`.
  - BLTU→SLTU; BGEU→SLTU with `br_invert=1`.
  - funct3 010/011 are illegal.
- **Illegal or unhandled opcode:** `alu_sel=ALU_INVALID`, `illegal=1`, `rd_we=0`, `is_branch=0`, `a=b=0`. The entry still issues so the exception path sees it.
- `rd=instr[11:7]` for every instruction. `rd_we=1` only for legal OP/OP-IMM/LUI/AUIPC with `rd!=0`.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is presented with `out_valid=1` after edge N.
- The entry holds stable while `out_valid && !out_ready`. `in_ready=0` in that case, so there is no overwrite.
- Full throughput: when `out_valid && out_ready && in_valid`, the entry is replaced the same edge and `out_valid` stays 1.
- If `out_ready` is high and nothing is accepted, `out_valid` goes to 0 at the next edge.
- `flush` at edge N:
  - `out_valid=0` after N; the held entry and any same-cycle input are dropped.
  - `in_ready` is 0 during the flush cycle.
  - Flush has priority over every other event.
- Reset (asynchronous, any time, including mid-stall):
  - `out_valid=0`, `alu_a=alu_b=0`, `alu_sel=ALU_NOP`, `rd=0`, `rd_we=is_branch=br_invert=illegal=0`.
  - `in_ready` follows its equation, so it is 1 in reset unless `flush` is high.
- Output payload registers load only on accept. Payload is don't-care while `out_valid=0` but must not change between accepts.

## Structure
- Shared package `issue_pkg`:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, BRANCH);
  - funct3/funct7 constants;
  - packed struct `issue_t` holding the output payload.
- ALU operation codes come from the existing `` `ALU_*`` definitions in `types.sv`. Do not redefine them.
- One combinational sub-module, `imm_gen`: instruction in, I/U immediates and shamt out.
- `alu_issue` contains the decode logic, payload register and handshake.

## Test plan
- Reset mid-stall:
  - assert `rst` asynchronously with `out_valid=1, out_ready=0`;
  - all outputs go to reset values before the next edge;
  - after release, `in_ready=1` (with `flush` low).
- `ADDI x5,x1,-1` with rs1=0x10 → next cycle `alu_sel=ALU_ADD`, `a=0x10`, `b=0xFFFFFFFF`, `rd=5`, `rd_we=1`.
- `SRAI x3,x2,4` (0x40415193) → `alu_sel=ALU_SRA`, `b=4`.
- Same encoding with funct7=0100001 → `illegal=1`, `alu_sel=ALU_INVALID`, `rd_we=0`.
- `BGEU` with rs1=1, rs2=2 → `alu_sel=ALU_SLTU`, `is_branch=1`, `br_invert=1`, `rd_we=0`.
- `AUIPC x1,0x12345` at pc=0x100 → `a=0x100`, `b=0x12345000`, `alu_sel=ALU_ADD`.
- `LUI x0,1` → `rd_we=0`.
- Backpressure:
  - hold `out_ready=0` for 3 cycles → payload is stable and `in_ready=0`;
  - then `out_ready=1` with `in_valid=1` every cycle → one instruction per cycle;
  - `flush` during a stall → `out_valid=0` next cycle and the same-cycle input is dropped.
